cpu_run_ctrl: RTL and testbench

- Run/halt/single-step/breakpoint sequencer for the 8-bit RISC CPU datapath.
- Sits between the 10 Hz ClkDiv tick and the Cen inputs of ProgCounter, Registers and both Reg8 output latches.
- Gates each instruction-execute tick according to the front-panel controls, the breakpoint compare on PC, and a halt opcode.
- Counts retired instructions for display.

---
 rtl/cpu_ctrl_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 53 +++++
 rtl/cpu_run_ctrl.sv | 104 ++++++++++
 tb/tb_cpu_run_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// cpu_ctrl_pkg : shared encodings for the CPU run/halt/step sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_e;

  localparam logic [3:0] HALT_OP = 4'hF;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// btn_debounce : 2-flop synchroniser, stable-level filter, rising-edge pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int DebCnt = 1000000
) (
  input  logic Clk100MHz,
  input  logic Clr,
  input  logic BtnIn,
  output logic Rise
);

  localparam int            CW       = $clog2(DebCnt + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DebCnt - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q;

  // cnt_q holds how many consecutive synchronised samples have disagreed with stable_q
  always_ff @(posedge Clk100MHz) begin
    if (!Clr) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= BtnIn;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync2_q;
        rise_q   <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign Rise = rise_q;

endmodule

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
// ============================================================================
// cpu_run_ctrl : run/halt/single-step/breakpoint gate for the datapath Cen
// Rev 1.0
// ============================================================================
`default_nettype none

module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int         DebCnt = 1000000,
  parameter logic [3:0] HaltOp = HALT_OP,
  parameter int         CntW   = 16
) (
  input  logic            Clk100MHz,
  input  logic            Clr,
  input  logic            Tick,
  input  logic            RunSw,
  input  logic            StepBtn,
  input  logic            BrkEn,
  input  logic [7:0]      BrkAddr,
  input  logic [7:0]      PC,
  input  logic [3:0]      Opcode,
  output logic            CpuCen,
  output logic            Halted,
  output logic [1:0]      State,
  output logic [CntW-1:0] InstrCount
);

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic [CntW-1:0]   cnt_q;
  logic              step_rise;
  logic              brk_hit;
  logic              cen;

  btn_debounce #(.DebCnt(DebCnt)) u_step_deb (
    .Clk100MHz (Clk100MHz),
    .Clr       (Clr),
    .BtnIn     (StepBtn),
    .Rise      (step_rise)
  );

  assign brk_hit = (BrkEn && (PC == BrkAddr)) || (Opcode == HaltOp);

  always_comb begin
    cen = 1'b0;
    if (Clr) begin
      case (state_q)
        ST_RUN:  cen = Tick && !brk_hit;
        ST_STEP: cen = Tick;
        default: cen = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT: begin
        if (pend_q)     state_d = ST_STEP;
        else if (RunSw) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!RunSw)                state_d = ST_HALT;
        else if (Tick && brk_hit)  state_d = ST_BREAK;
      end
      ST_STEP: begin
        if (Tick) state_d = ST_HALT;
      end
      ST_BREAK: begin
        if (pend_q)      state_d = ST_STEP;
        else if (!RunSw) state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
  end

  // A press seen while running is consumed without effect
  always_comb begin
    pend_d = pend_q;
    if ((state_d == ST_STEP) && (state_q != ST_STEP)) pend_d = 1'b0;
    if (step_rise) pend_d = (state_q != ST_RUN);
  end

  always_ff @(posedge Clk100MHz) begin
    if (!Clr) begin
      state_q <= ST_HALT;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (cen) cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign CpuCen     = cen;
  assign Halted     = (state_q == ST_HALT) || (state_q == ST_BREAK);
  assign State      = state_q;
  assign InstrCount = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// ============================================================================
// tb_cpu_run_ctrl : directed + randomised bench with a cycle-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cpu_run_ctrl;

  localparam int DEB = 4;
  localparam int CW  = 8;

  localparam int M_HALT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STEP  = 2;
  localparam int M_BREAK = 3;

  logic          clk = 1'b0;
  logic          Clr, Tick, RunSw, StepBtn, BrkEn;
  logic [7:0]    BrkAddr, PC;
  logic [3:0]    Opcode;
  logic          CpuCen, Halted;
  logic [1:0]    State;
  logic [CW-1:0] InstrCount;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.DebCnt(DEB), .HaltOp(4'hF), .CntW(CW)) dut (
    .Clk100MHz  (clk),
    .Clr        (Clr),
    .Tick       (Tick),
    .RunSw      (RunSw),
    .StepBtn    (StepBtn),
    .BrkEn      (BrkEn),
    .BrkAddr    (BrkAddr),
    .PC         (PC),
    .Opcode     (Opcode),
    .CpuCen     (CpuCen),
    .Halted     (Halted),
    .State      (State),
    .InstrCount (InstrCount)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int tick_phase = 0;
  int pulses = 0;

  // Reference model: sequencer mode, press flag, filtered button level, raw sample history
  int            m_mode;
  logic          m_pend, m_stable, m_rise;
  logic [CW-1:0] m_count;
  logic          hist [0:7];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode   = M_HALT;
    m_pend   = 1'b0;
    m_stable = 1'b0;
    m_rise   = 1'b0;
    m_count  = '0;
    for (int i = 0; i < 8; i++) hist[i] = 1'b0;
  endtask

  // One clock cycle: inputs were set by the caller at the preceding negedge
  task automatic cyc();
    logic brk, cen, rise_now, pend, all_differ;
    int   nxt;
    Tick = (tick_phase == 9);
    tick_phase = (tick_phase + 1) % 10;
    #1;
    brk = (BrkEn && (PC == BrkAddr)) || (Opcode == 4'hF);
    cen = Clr && (((m_mode == M_RUN) && Tick && !brk) || ((m_mode == M_STEP) && Tick));
    check("cpucen", {31'd0, CpuCen}, {31'd0, cen});
    check("state",  {30'd0, State},  m_mode);
    check("halted", {31'd0, Halted}, {31'd0, (m_mode == M_HALT) || (m_mode == M_BREAK)});
    check("count",  {24'd0, InstrCount}, {24'd0, m_count});
    if (CpuCen === 1'b1) pulses++;

    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = StepBtn;
    if (!Clr) begin
      model_reset();
    end else begin
      rise_now = m_rise;
      pend     = m_pend;
      nxt      = m_mode;
      // level accepted once the last DEB synchronised samples all disagree with it
      all_differ = 1'b1;
      for (int i = 2; i < DEB + 2; i++) if (hist[i] == m_stable) all_differ = 1'b0;
      m_rise = 1'b0;
      if (all_differ) begin
        m_stable = ~m_stable;
        m_rise   = m_stable;
      end
      if (cen) m_count = m_count + 1'b1;
      if (m_mode == M_HALT) begin
        if (m_pend) nxt = M_STEP; else if (RunSw) nxt = M_RUN;
      end else if (m_mode == M_RUN) begin
        if (!RunSw) nxt = M_HALT; else if (Tick && brk) nxt = M_BREAK;
      end else if (m_mode == M_STEP) begin
        if (Tick) nxt = M_HALT;
      end else begin
        if (m_pend) nxt = M_STEP; else if (!RunSw) nxt = M_HALT;
      end
      if ((nxt == M_STEP) && (m_mode != M_STEP)) pend = 1'b0;
      if (rise_now) pend = (m_mode != M_RUN);
      m_mode = nxt;
      m_pend = pend;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic press(input int hold);
    StepBtn = 1'b1;
    cycles(hold);
    StepBtn = 1'b0;
  endtask

  initial begin
    Clr = 1'b0; Tick = 1'b0; RunSw = 1'b1; StepBtn = 1'b0; BrkEn = 1'b0;
    BrkAddr = 8'h00; PC = 8'h00; Opcode = 4'h1;
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // Reset held with RunSw=1, then release
    cycles(2);
    check("rst_state", {30'd0, State}, 0);
    check("rst_count", {24'd0, InstrCount}, 0);
    Clr = 1'b1;
    cycles(2);
    check("run_after_rst", {30'd0, State}, M_RUN);

    // Plain run: five ticks give five pulses
    pulses = 0;
    cycles(48);
    check("run_pulses", pulses, 5);
    check("run_count", {24'd0, InstrCount}, 5);

    // Breakpoint on PC
    BrkEn = 1'b1; BrkAddr = 8'h07; PC = 8'h07;
    pulses = 0;
    cycles(40);
    check("brk_pulses", pulses, 0);
    check("brk_state", {30'd0, State}, M_BREAK);
    check("brk_halted", {31'd0, Halted}, 1);

    // Step over breakpoint; RUN resumes and breaks again on the same PC
    press(6);
    cycles(40);
    check("step_count", {24'd0, InstrCount}, 6);
    check("step_rebrk", {30'd0, State}, M_BREAK);

    // Bouncing button in HALT yields one step
    RunSw = 1'b0;
    cycles(2);
    for (int i = 0; i < 10; i++) begin
      StepBtn = ~StepBtn;
      cycles(2);
    end
    press(8);
    cycles(40);
    check("bounce_count", {24'd0, InstrCount}, 7);
    check("bounce_state", {30'd0, State}, M_HALT);

    // Press during RUN is discarded
    BrkEn = 1'b0; RunSw = 1'b1;
    cycles(20);
    press(8);
    cycles(20);
    RunSw = 1'b0;
    cycles(1);
    pulses = 0;
    cycles(40);
    check("run_press_discard", pulses, 0);

    // Halt opcode
    RunSw = 1'b1; Opcode = 4'hF;
    pulses = 0;
    cycles(30);
    check("haltop_pulses", pulses, 0);
    check("haltop_state", {30'd0, State}, M_BREAK);

    // Counter wrap via a single step
    RunSw = 1'b0; Opcode = 4'h1;
    cycles(2);
    RunSw = 1'b1;
    for (int i = 0; i < 3000 && m_count != 8'hFF; i++) cyc();
    RunSw = 1'b0;
    cycles(15);
    check("wrap_pre", {24'd0, InstrCount}, 32'hFF);
    press(8);
    cycles(40);
    check("wrap_post", {24'd0, InstrCount}, 0);

    // Reset in the middle of debouncing abandons the press
    StepBtn = 1'b1;
    cycles(4);
    Clr = 1'b0; StepBtn = 1'b0;
    cycles(1);
    Clr = 1'b1;
    pulses = 0;
    cycles(40);
    check("rst_mid_deb", pulses, 0);

    // Randomised mix
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(39) == 0) RunSw = ~RunSw;
      if ($urandom_range(7) == 0)  StepBtn = ~StepBtn;
      if ($urandom_range(49) == 0) BrkEn = ~BrkEn;
      if ($urandom_range(4) == 0)  PC = 8'($urandom_range(15));
      if ($urandom_range(99) == 0) BrkAddr = 8'($urandom_range(15));
      if ($urandom_range(9) == 0)  Opcode = ($urandom_range(7) == 0) ? 4'hF : 4'($urandom_range(14));
      Clr = ($urandom_range(299) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
